// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory signal bundle for mem_port_arbiter
//
// Ports (slave = arbiter view, master = requesters + memory view):
//   if_req_i, if_addr_i[31:0]                       fetch request, byte address
//   if_gnt_o, if_rvalid_o, if_rdata_o[31:0]         fetch grant and response
//   ls_req_i, ls_we_i, ls_addr_i[31:0], ls_wdata_i  load/store request
//   ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o     load/store grant and response
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o     memory access (word address)
//   mem_rdata_i[31:0]                               memory read data, one cycle after a read
interface mem_port_arbiter_if #(
   parameter int MEMORY_SIZE = 1024
);
   localparam int AW = $clog2(MEMORY_SIZE);

   logic          if_req_i;
   logic [31:0]   if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [31:0]   if_rdata_o;

   logic          ls_req_i;
   logic          ls_we_i;
   logic [31:0]   ls_addr_i;
   logic [31:0]   ls_wdata_i;
   logic          ls_gnt_o;
   logic          ls_rvalid_o;
   logic [31:0]   ls_rdata_o;
   logic          ls_err_o;

   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
      output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
      input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  asynchronous active-high reset
//   bus    mem_port_arbiter_if.slave: fetch and load/store request/response, memory port
// Parameters:
//   MEMORY_SIZE    memory depth in 32-bit words (power of two)
//   MAX_LS_STREAK  consecutive load/store grants allowed while a fetch waits
module mem_port_arbiter #(
   parameter int MEMORY_SIZE   = 1024,
   parameter int MAX_LS_STREAK = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   mem_port_arbiter_if.slave bus
);
   localparam int AW = $clog2(MEMORY_SIZE);
   localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

   // Records what was granted last cycle so exactly one response fires now.
   typedef enum logic [2:0] {
      TAG_NONE,
      TAG_IF,
      TAG_LS,
      TAG_LS_ST,
      TAG_LS_ERR
   } tag_e;

   tag_e          tag_q, tag_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          ls_win;
   logic          ls_misaligned;
   logic          if_gnt;
   logic          ls_gnt;
   logic          ls_mem;

   // Address bits outside the word index are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr_i[31:AW+2], bus.if_addr_i[1:0],
                               bus.ls_addr_i[31:AW+2]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_q    <= TAG_NONE;
         streak_q <= '0;
      end else begin
         tag_q    <= tag_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      tag_d         = TAG_NONE;
      streak_d      = streak_q;
      ls_misaligned = (bus.ls_addr_i[1:0] != 2'b00);
      // Load/store wins contention until it has starved the fetch long enough.
      ls_win        = bus.ls_req_i && !(bus.if_req_i && (streak_q == STREAK_MAX));
      ls_gnt        = !rst_i && ls_win;
      if_gnt        = !rst_i && bus.if_req_i && !ls_win;
      ls_mem        = ls_gnt && !ls_misaligned;

      if (if_gnt) begin
         tag_d = TAG_IF;
      end else if (ls_gnt) begin
         if (ls_misaligned) begin
            tag_d = TAG_LS_ERR;
         end else if (bus.ls_we_i) begin
            tag_d = TAG_LS_ST;
         end else begin
            tag_d = TAG_LS;
         end
      end

      if (!bus.if_req_i || if_gnt) begin
         streak_d = '0;
      end else if (ls_gnt && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + SW'(1);
      end
   end

   assign bus.if_gnt_o    = if_gnt;
   assign bus.ls_gnt_o    = ls_gnt;

   // A misaligned access is granted but never reaches the memory.
   assign bus.mem_en_o    = if_gnt || ls_mem;
   assign bus.mem_we_o    = ls_mem && bus.ls_we_i;
   assign bus.mem_addr_o  = if_gnt ? bus.if_addr_i[AW+1:2] :
                            ls_gnt ? bus.ls_addr_i[AW+1:2] : '0;
   assign bus.mem_wdata_o = ls_gnt ? bus.ls_wdata_i : '0;

   assign bus.if_rvalid_o = (tag_q == TAG_IF);
   assign bus.if_rdata_o  = (tag_q == TAG_IF) ? bus.mem_rdata_i : '0;
   assign bus.ls_rvalid_o = (tag_q == TAG_LS) || (tag_q == TAG_LS_ST) || (tag_q == TAG_LS_ERR);
   assign bus.ls_rdata_o  = (tag_q == TAG_LS) ? bus.mem_rdata_i : '0;
   assign bus.ls_err_o    = (tag_q == TAG_LS_ERR);
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_SIZE, default 1024, memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter MAX_LS_STREAK, default 3, max consecutive load/store grants while a fetch waits.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 if_req_i  input  1  instruction-fetch request.
REQ-006 if_addr_i  input  32  fetch byte address.
REQ-007 if_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o  output  1  fetch response valid.
REQ-009 if_rdata_o  output  32  fetched instruction word.
REQ-010 ls_req_i  input  1  load/store request.
REQ-011 ls_we_i  input  1  1 = store, 0 = load.
REQ-012 ls_addr_i  input  32  load/store byte address.
REQ-013 ls_wdata_i  input  32  store data.
REQ-014 ls_gnt_o  output  1  load/store request accepted this cycle.
REQ-015 ls_rvalid_o  output  1  load/store completion valid.
REQ-016 ls_rdata_o  output  32  load data; 0 for stores and errors.
REQ-017 ls_err_o  output  1  misaligned-access error, qualified by ls_rvalid_o.
REQ-018 mem_en_o, mem_we_o  output  1 each  memory access enable, write enable.
REQ-019 mem_addr_o  output  log2(MEMORY_SIZE)  word address.
REQ-020 mem_wdata_o  output  32  memory write data; mem_rdata_i  input  32  read data, valid one cycle after a read-enabled access.

Function
REQ-021 SHALL grant at most one requester per cycle; grant is combinational from requests and state, same cycle as request.
REQ-022 Uncontended request SHALL be granted immediately; no request -> mem_en_o = 0, both gnt = 0.
REQ-023 On contention, ls SHALL win unless streak counter == MAX_LS_STREAK, in which case if SHALL win.
REQ-024 Streak counter SHALL increment on each ls grant made while if_req_i = 1, saturate at MAX_LS_STREAK, clear to 0 on any if grant or any cycle with if_req_i = 0.
REQ-025 On grant: mem_en_o = 1, mem_addr_o = granted addr[log2(MEMORY_SIZE)+1:2] (upper bits ignored, address wraps), mem_we_o = ls_we_i for ls else 0, mem_wdata_o = ls_wdata_i for ls else 0.
REQ-026 Ls request with ls_addr_i[1:0] != 0 SHALL be granted but SHALL NOT enable memory (mem_en_o = 0); next cycle ls_rvalid_o = 1, ls_err_o = 1, ls_rdata_o = 0.
REQ-027 A registered response tag, states NONE/IF/LS/LS_ST/LS_ERR, SHALL record the grant of each cycle; next cycle drives exactly one rvalid.
REQ-028 Latency SHALL be exactly 1 cycle grant -> rvalid; IF: if_rdata_o = mem_rdata_i; LS load: ls_rdata_o = mem_rdata_i; LS_ST: ls_rvalid_o = 1, ls_rdata_o = 0.
REQ-029 Back-to-back grants every cycle SHALL be supported (pipelined, one response per cycle).
REQ-030 Non-selected rdata output SHALL be 0; ls_err_o = 0 except in LS_ERR.
REQ-031 Requesters hold req/addr/data stable until granted; arbiter SHALL NOT latch ungranted requests.

Reset
REQ-032 While rst_i = 1: tag = NONE, streak = 0, all rvalid/err/gnt/mem_en_o/mem_we_o = 0, all data/address outputs 0.
REQ-033 Reset asserted mid-operation SHALL discard any pending response (no rvalid after reset release for pre-reset grants).
REQ-034 First grant possible in first rising edge cycle after rst_i falls.

Verification
REQ-035 Fetch only: if_req_i=1, if_addr_i=0x10 -> if_gnt_o=1, mem_addr_o=4 same cycle; next cycle if_rvalid_o=1, if_rdata_o=mem_rdata_i.
REQ-036 Contention: both req held 6 cycles, MAX_LS_STREAK=3 -> grant order LS,LS,LS,IF,LS,LS.
REQ-037 Store: ls_we_i=1, addr 0x20, wdata 0xDEADBEEF -> mem_we_o=1, mem_addr_o=8, mem_wdata_o=0xDEADBEEF; next cycle ls_rvalid_o=1, ls_rdata_o=0.
REQ-038 Misaligned load addr 0x22 -> ls_gnt_o=1, mem_en_o=0; next cycle ls_rvalid_o=1, ls_err_o=1.
REQ-039 Wrap: if_addr_i=0x1004, MEMORY_SIZE=1024 -> mem_addr_o=1.
REQ-040 Reset pulse in cycle after a load grant -> no ls_rvalid_o, all outputs 0, streak 0.
